// File: rtl/sincos_table_gen.sv
// sincos_table_gen: fills the sin/cos playback memory with one half period of
// a tone, one CORDIC evaluation per entry, over the clk_2 register port.
// While idle the same port is handed straight through to the host.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | host owns the memory port; waiting for start
// S_SETUP | fold phase into the CORDIC range, load x/y/z
// S_ROT   | ITER CORDIC micro-rotations
// S_PACK  | quadrant fix-up, clamp, present the entry write
// S_WRITE | hold the write until the memory acknowledges it
module sincos_table_gen #(
    parameter int          pcmaw = 10,
    parameter logic [15:0] UNIT1 = 16'h4000,
    parameter int          ITER  = 14
) (
    input  logic             clk_2,
    input  logic             rst,
    input  logic             start,
    input  logic [pcmaw:0]   sin_length,
    input  logic [31:0]      phase_inc,
    output logic             busy,
    output logic             done,
    input  logic [pcmaw-1:0] host_addr,
    input  logic             host_rd,
    input  logic             host_wr,
    input  logic [31:0]      host_writedata,
    output logic             host_ready,
    output logic [31:0]      host_readdata,
    output logic [pcmaw-1:0] mem_addr,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [31:0]      mem_writedata,
    input  logic             mem_ready,
    input  logic [31:0]      mem_readdata
);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ROT, S_PACK, S_WRITE} state_t;

    // Start vector pre-scaled by the CORDIC gain so the result lands on UNIT1.
    localparam longint            X_INIT_L = (longint'(UNIT1) * 64'd607253 + 64'd500000) / 64'd1000000;
    localparam logic signed [17:0] X_INIT  = 18'(X_INIT_L);
    localparam logic signed [17:0] LIM     = $signed({2'b00, UNIT1});
    localparam logic signed [17:0] QUARTER = 18'sh04000;

    state_t             state;
    logic [pcmaw-1:0]   k;
    logic [31:0]        phase;
    logic [pcmaw:0]     len;
    logic [31:0]        inc;
    logic signed [17:0] x, y, z;
    logic [3:0]         iter;
    logic               swap;
    logic               gen_wr;
    logic [pcmaw-1:0]   gen_addr;
    logic [31:0]        gen_data;

    logic signed [17:0] xs, ys, i_raw, q_raw;

    // atan(2^-i) in 2^16-per-turn angle units.
    function automatic logic signed [17:0] atan_lut(input logic [3:0] i);
        case (i)
            4'd0:    atan_lut = 18'sd8192;
            4'd1:    atan_lut = 18'sd4836;
            4'd2:    atan_lut = 18'sd2555;
            4'd3:    atan_lut = 18'sd1297;
            4'd4:    atan_lut = 18'sd651;
            4'd5:    atan_lut = 18'sd326;
            4'd6:    atan_lut = 18'sd163;
            4'd7:    atan_lut = 18'sd81;
            4'd8:    atan_lut = 18'sd41;
            4'd9:    atan_lut = 18'sd20;
            4'd10:   atan_lut = 18'sd10;
            4'd11:   atan_lut = 18'sd5;
            4'd12:   atan_lut = 18'sd3;
            4'd13:   atan_lut = 18'sd1;
            4'd14:   atan_lut = 18'sd1;
            default: atan_lut = 18'sd0;
        endcase
    endfunction

    // Limit to +/-UNIT1 so gain overshoot never wraps the 16-bit sample.
    function automatic logic [15:0] clamp16(input logic signed [17:0] v);
        if (v > LIM)
            clamp16 = LIM[15:0];
        else if (v < -LIM)
            clamp16 = 16'((-LIM));
        else
            clamp16 = v[15:0];
    endfunction

    // Shifted operands for the current micro-rotation and quadrant-restored outputs.
    always_comb begin
        xs    = x >>> iter;
        ys    = y >>> iter;
        i_raw = swap ? -y : x;
        q_raw = swap ? x : y;
    end

    // Memory port ownership: host when idle, generator while busy.
    always_comb begin
        if (busy) begin
            mem_addr      = gen_addr;
            mem_rd        = 1'b0;
            mem_wr        = gen_wr;
            mem_writedata = gen_data;
            host_ready    = 1'b0;
        end else begin
            mem_addr      = host_addr;
            mem_rd        = host_rd;
            mem_wr        = host_wr;
            mem_writedata = host_writedata;
            host_ready    = mem_ready;
        end
    end

    assign host_readdata = mem_readdata;

    // Table generation sequencer and CORDIC datapath.
    always_ff @(posedge clk_2 or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            k        <= '0;
            phase    <= '0;
            len      <= '0;
            inc      <= '0;
            x        <= '0;
            y        <= '0;
            z        <= '0;
            iter     <= '0;
            swap     <= 1'b0;
            gen_wr   <= 1'b0;
            gen_addr <= '0;
            gen_data <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len   <= sin_length;
                        inc   <= phase_inc;
                        k     <= '0;
                        phase <= '0;
                        if (sin_length == '0) begin
                            done <= 1'b1;
                        end else begin
                            busy  <= 1'b1;
                            state <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    x    <= X_INIT;
                    y    <= '0;
                    iter <= '0;
                    if (phase[31:30] == 2'b00) begin
                        z    <= $signed({2'b00, phase[31:16]});
                        swap <= 1'b0;
                    end else begin
                        z    <= $signed({2'b00, phase[31:16]}) - QUARTER;
                        swap <= 1'b1;
                    end
                    state <= S_ROT;
                end
                S_ROT: begin
                    if (z[17]) begin
                        x <= x + ys;
                        y <= y - xs;
                        z <= z + atan_lut(iter);
                    end else begin
                        x <= x - ys;
                        y <= y + xs;
                        z <= z - atan_lut(iter);
                    end
                    iter <= iter + 4'd1;
                    if (iter == 4'(ITER - 1))
                        state <= S_PACK;
                end
                S_PACK: begin
                    gen_addr <= k;
                    gen_data <= {clamp16(i_raw), clamp16(q_raw)};
                    gen_wr   <= 1'b1;
                    state    <= S_WRITE;
                end
                S_WRITE: begin
                    if (mem_ready) begin
                        gen_wr <= 1'b0;
                        if (k == len[pcmaw:1]) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            k     <= k + pcmaw'(1);
                            phase <= phase + inc;
                            state <= S_SETUP;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
